// File: rtl/keypad_entry_buffer_if.sv
// Key-input and entry-result signals between the keypad encoder side and
// the entry buffer; slave is the buffer's view.
interface keypad_entry_buffer_if #(
  parameter int unsigned DIGITS = 4
);
  logic [3:0]                     key_d;
  logic                           key_dav;
  logic [4*DIGITS-1:0]            entry;
  logic [$clog2(DIGITS+1)-1:0]    count;
  logic [4*DIGITS-1:0]            value;
  logic                           value_valid;
  logic                           key_event;
  logic                           overflow;

  modport master (
    output key_d, key_dav,
    input  entry, count, value, value_valid, key_event, overflow
  );

  modport slave (
    input  key_d, key_dav,
    output entry, count, value, value_valid, key_event, overflow
  );
endinterface

// File: rtl/keypad_entry_buffer.sv
// Debounces keypad presses/releases and shifts BCD digits into an entry buffer;
// ENTER_CODE commits the buffer to value with a one-cycle strobe.
module keypad_entry_buffer #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned ENTER_CODE      = 15
) (
  input logic                  clk,
  input logic                  rst,
  keypad_entry_buffer_if.slave bus
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NW = $clog2(DIGITS + 1);
  localparam int unsigned EW = 4 * DIGITS;
  localparam logic [CW-1:0] DcLast    = CW'(DEBOUNCE_CYCLES);
  localparam logic [NW-1:0] Full      = NW'(DIGITS);
  localparam logic [3:0]    EnterCode = 4'(ENTER_CODE);

  typedef enum logic [1:0] {StIdle, StDebounce, StWaitRelease} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    code_q, code_d;
  logic          accept;

  logic [EW-1:0] entry_q, entry_d;
  logic [EW-1:0] value_q, value_d;
  logic [NW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          event_q, event_d;
  logic          ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= '0;
      entry_q <= '0;
      value_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      event_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      entry_q <= entry_d;
      value_q <= value_d;
      count_q <= count_d;
      valid_q <= valid_d;
      event_q <= event_d;
      ovf_q   <= ovf_d;
    end
  end

  // Press/release debounce; code_d is the accepted code whenever accept is set.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    accept  = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    unique case (state_q)
      StIdle: begin
        if (bus.key_dav) begin
          code_d = bus.key_d;
          if (DEBOUNCE_CYCLES == 1) begin
            accept  = 1'b1;
            state_d = StWaitRelease;
            cnt_d   = '0;
          end else begin
            state_d = StDebounce;
            cnt_d   = CW'(1);
          end
        end
      end
      StDebounce: begin
        if (!bus.key_dav) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (bus.key_d != code_q) begin
          code_d = bus.key_d;
          cnt_d  = CW'(1);
        end else if (cnt_inc == DcLast) begin
          accept  = 1'b1;
          state_d = StWaitRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitRelease: begin
        if (bus.key_dav) begin
          cnt_d = '0;
        end else if (cnt_inc == DcLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    entry_d = entry_q;
    value_d = value_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    event_d = 1'b0;
    if (accept) begin
      event_d = 1'b1;
      if (code_d == EnterCode) begin
        value_d = entry_q;
        valid_d = 1'b1;
        entry_d = '0;
        count_d = '0;
        ovf_d   = 1'b0;
      end else if (code_d <= 4'd9) begin
        if (count_q == Full) begin
          ovf_d = 1'b1;
        end else begin
          entry_d = EW'({entry_q, code_d});
          count_d = count_q + NW'(1);
        end
      end
    end
  end

  assign bus.entry       = entry_q;
  assign bus.count       = count_q;
  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.key_event   = event_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Table-driven press sequences with a scoreboard of expected accept results,
// plus hand-written debounce, hold and reset corner cases.
module tb_keypad_entry_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_entry_buffer_if #(.DIGITS(4)) bus ();

  keypad_entry_buffer #(
    .DIGITS         (4),
    .DEBOUNCE_CYCLES(8),
    .ENTER_CODE     (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] entry;
    logic [2:0]  count;
    logic [15:0] value;
    bit          vv;
    bit          ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  code;
    int          hold;
    int          gap;
    bit          accept;
    logic [15:0] entry;
    logic [2:0]  count;
    logic [15:0] value;
    bit          vv;
    bit          ovf;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[13];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   prev_ev  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    bus.key_dav = 1'b1;
    bus.key_d   = code;
    tick(hold);
    bus.key_dav = 1'b0;
    bus.key_d   = 4'($urandom);
    tick(gap);
  endtask

  task automatic idle_check(input string tag, input exp_t e);
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    chk({tag, "_entry"}, 32'(bus.entry), 32'(e.entry));
    chk({tag, "_count"}, 32'(bus.count), 32'(e.count));
    chk({tag, "_value"}, 32'(bus.value), 32'(e.value));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(e.ovf));
    chk({tag, "_quiet"}, 32'({bus.key_event, bus.value_valid}), 32'd0);
  endtask

  // Scoreboard: every key_event must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst) begin
      prev_ev <= 1'b0;
    end else begin
      prev_ev <= bus.key_event;
      if (bus.value_valid) chk("valid_with_event", 32'(bus.key_event), 32'd1);
      if (bus.key_event) begin
        chk("event_one_cycle", 32'(prev_ev), 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: got key_event=1 entry=%h expected no event",
                   bus.entry);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ev_entry", 32'(bus.entry), 32'(e.entry));
          chk("ev_count", 32'(bus.count), 32'(e.count));
          chk("ev_valid", 32'(bus.value_valid), 32'(e.vv));
          chk("ev_ovf", 32'(bus.overflow), 32'(e.ovf));
          if (e.vv) chk("ev_value", 32'(bus.value), 32'(e.value));
        end
      end
    end
  end

  initial begin
    exp_t e;
    tbl[0]  = '{4'd1,  8, 8, 1'b1, 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{4'd2,  8, 8, 1'b1, 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{4'd3,  8, 8, 1'b1, 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{4'd15, 8, 8, 1'b1, 16'h0000, 3'd0, 16'h0123, 1'b1, 1'b0};
    tbl[4]  = '{4'd5,  7, 8, 1'b0, 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0};
    tbl[5]  = '{4'd10, 8, 8, 1'b1, 16'h0000, 3'd0, 16'h0123, 1'b0, 1'b0};
    tbl[6]  = '{4'd15, 8, 8, 1'b1, 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b0};
    tbl[7]  = '{4'd1,  8, 8, 1'b1, 16'h0001, 3'd1, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{4'd2,  8, 8, 1'b1, 16'h0012, 3'd2, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{4'd3,  8, 8, 1'b1, 16'h0123, 3'd3, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{4'd4,  8, 8, 1'b1, 16'h1234, 3'd4, 16'h0000, 1'b0, 1'b0};
    tbl[11] = '{4'd5,  8, 8, 1'b1, 16'h1234, 3'd4, 16'h0000, 1'b0, 1'b1};
    tbl[12] = '{4'd15, 8, 8, 1'b1, 16'h0000, 3'd0, 16'h1234, 1'b1, 1'b0};

    bus.key_dav = 1'b0;
    bus.key_d   = 4'd0;
    rst = 1'b1;
    tick(3);
    idle_check("reset", '{16'h0, 3'd0, 16'h0, 1'b0, 1'b0});
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 13; i++) begin
      e = '{tbl[i].entry, tbl[i].count, tbl[i].value, tbl[i].vv, tbl[i].ovf};
      if (tbl[i].accept) sb.push_back(e);
      press(tbl[i].code, tbl[i].hold, tbl[i].gap);
      e.vv = 1'b0;
      idle_check($sformatf("v%0d", i), e);
    end

    // Code changes 5->6 mid-debounce: only 6 is accepted, once.
    e = '{16'h0006, 3'd1, 16'h1234, 1'b0, 1'b0};
    sb.push_back(e);
    bus.key_dav = 1'b1;
    bus.key_d   = 4'd5;
    tick(3);
    bus.key_d = 4'd6;
    tick(8);
    bus.key_dav = 1'b0;
    tick(8);
    idle_check("switch", e);

    // Long hold with a short dropout must not repeat.
    e = '{16'h0069, 3'd2, 16'h1234, 1'b0, 1'b0};
    sb.push_back(e);
    bus.key_dav = 1'b1;
    bus.key_d   = 4'd9;
    tick(40);
    bus.key_dav = 1'b0;
    tick(3);
    bus.key_dav = 1'b1;
    tick(57);
    bus.key_dav = 1'b0;
    tick(8);
    idle_check("hold", e);

    // Reset on the 5th debounce sample discards the pending key.
    bus.key_dav = 1'b1;
    bus.key_d   = 4'd7;
    tick(4);
    rst = 1'b1;
    bus.key_dav = 1'b0;
    tick(2);
    idle_check("midrst", '{16'h0, 3'd0, 16'h0, 1'b0, 1'b0});
    rst = 1'b0;
    tick(2);
    e = '{16'h0008, 3'd1, 16'h0000, 1'b0, 1'b0};
    sb.push_back(e);
    press(4'd8, 8, 8);
    idle_check("postrst", e);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
